// File: rtl/m_7seg_scan.sv
// m_7seg_scan: multiplexed controller for a NUM_DIG-digit 7-segment display.
//
// Holds a BCD up-counter with run/stop control, synchronous clear and load. It
// time-shares one 8-bit segment bus across the digits by strobing one digit
// enable at a time.
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-clk pulse: enter RUN
//   stop       in   one-clk pulse: enter STOP (start+stop together: no change)
//   clr        in   synchronous clear of the counter (highest priority)
//   load       in   synchronous load of load_val (digits > 9 stored as 0)
//   load_val   in   BCD load value, digit 0 = bits [3:0]
//   LED        out  segment bus {a,b,c,d,e,f,g,dp}, 1 = lit, dp always 0
//   AN         out  digit enables, polarity set by AN_ACTIVE_LOW
//   count_bcd  out  current counter value (registered)
//   ovf        out  one-clk pulse when the counter wraps all-9s -> 0
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   defined   - leading zero digits (never digit 0) drive LED = 8'h00
//   undefined - every digit shows its code, including leading zeros

module m_7seg_scan #(
    parameter int unsigned NUM_DIG       = 4,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned TICK_DIV      = 50000000,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clr,
    input  logic                   load,
    input  logic [4*NUM_DIG-1:0]   load_val,
    output logic [7:0]             LED,
    output logic [NUM_DIG-1:0]     AN,
    output logic [4*NUM_DIG-1:0]   count_bcd,
    output logic                   ovf
);

    localparam int unsigned CntW  = 4 * NUM_DIG;
    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned RefW  = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [TickW-1:0]   TickLast = TickW'(TICK_DIV - 1);
    localparam logic [RefW-1:0]    RefLast  = RefW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]    IdxLast  = IdxW'(NUM_DIG - 1);
    // Deasserted level of every enable equals the polarity bit itself.
    localparam logic [NUM_DIG-1:0] AnOff    = {NUM_DIG{AN_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Segment decode, {a,b,c,d,e,f,g,dp}
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hfc;
            4'd1:    code = 8'h60;
            4'd2:    code = 8'hda;
            4'd3:    code = 8'hf2;
            4'd4:    code = 8'h66;
            4'd5:    code = 8'hb6;
            4'd6:    code = 8'hbe;
            4'd7:    code = 8'he0;
            4'd8:    code = 8'hfe;
            4'd9:    code = 8'hf6;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Run/stop FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        StStop,
        StRun
    } state_e;

    state_e state_q, state_d;
    logic   running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStop:  if (start && !stop) state_d = StRun;
            StRun:   if (stop && !start) state_d = StStop;
            default: state_d = StStop;
        endcase
    end

    always_comb begin
        running = 1'b0;
        unique case (state_q)
            StRun:   running = 1'b1;
            default: running = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Tick divider: advances only in RUN, holds in STOP so a resumed run
    // finishes the partial period.
    // ------------------------------------------------------------------
    logic [TickW-1:0] tick_q, tick_d;
    logic             tick_wrap;

    assign tick_wrap = running && (tick_q == TickLast);

    always_comb begin
        tick_d = tick_q;
        if (clr || load) begin
            tick_d = '0;
        end else if (running) begin
            tick_d = tick_wrap ? '0 : tick_q + TickW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // BCD counter
    // ------------------------------------------------------------------
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] count_inc;
    logic [CntW-1:0] load_clean;
    logic            all_nines;
    logic            inc_carry;
    logic            ovf_q, ovf_d;

    // Ripple increment; carry propagates only through digits that roll 9 -> 0.
    always_comb begin
        count_inc = count_q;
        all_nines = 1'b1;
        inc_carry = 1'b1;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (count_q[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (inc_carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    inc_carry           = 1'b0;
                end
            end
        end
    end

    // Non-decimal nibbles in the load value are stored as 0.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (load_val[4*i +: 4] <= 4'd9) begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clean;
        end else if (tick_wrap) begin
            count_d = count_inc;
            ovf_d   = all_nines;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit scan: free-running in both states
    // ------------------------------------------------------------------
    logic [RefW-1:0] ref_q, ref_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            ref_last;

    assign ref_last = (ref_q == RefLast);

    always_comb begin
        ref_d = ref_last ? '0 : ref_q + RefW'(1);
        idx_d = idx_q;
        if (ref_last) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q <= '0;
            idx_q <= '0;
        end else begin
            ref_q <= ref_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Display outputs, registered one clock behind idx_q / count_q
    // ------------------------------------------------------------------
    logic [3:0]         cur_digit;
    logic [NUM_DIG-1:0] an_onehot;
    logic               blank;
    logic [7:0]         led_q, led_d;
    logic [NUM_DIG-1:0] an_q, an_d;

    always_comb begin
        cur_digit = 4'd0;
        an_onehot = '0;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (IdxW'(i) == idx_q) begin
                cur_digit    = count_q[4*i +: 4];
                an_onehot[i] = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Walk from the top digit down; a digit is blanked when it and every
    // digit above it is zero. Digit 0 is outside the loop, so never blank.
    always_comb begin
        blank      = 1'b0;
        upper_zero = 1'b1;
        for (int i = int'(NUM_DIG) - 1; i > 0; i--) begin
            upper_zero = upper_zero && (count_q[4*i +: 4] == 4'd0);
            if (IdxW'(i) == idx_q) begin
                blank = upper_zero;
            end
        end
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_comb begin
        led_d = blank ? 8'h00 : seg_code(cur_digit);
        an_d  = an_onehot ^ AnOff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= 8'h00;
            an_q  <= AnOff;
        end else begin
            led_q <= led_d;
            an_q  <= an_d;
        end
    end

    assign LED       = led_q;
    assign AN        = an_q;
    assign count_bcd = count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_m_7seg_scan.sv
// Self-checking bench for m_7seg_scan (NUM_DIG=4, REFRESH_DIV=3, TICK_DIV=4,
// active-low digit enables). A behavioural model keeps the count as a plain
// decimal integer and the scan position as slot/phase integers; a negedge
// process compares every output against it each cycle.

module tb_m_7seg_scan;

    localparam int N  = 4;
    localparam int RD = 3;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            clr = 1'b0;
    logic            load = 1'b0;
    logic [4*N-1:0]  load_val = '0;
    logic [7:0]      LED;
    logic [N-1:0]    AN;
    logic [4*N-1:0]  count_bcd;
    logic            ovf;

    m_7seg_scan #(
        .NUM_DIG      (N),
        .REFRESH_DIV  (RD),
        .TICK_DIV     (TD),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .LED      (LED),
        .AN       (AN),
        .count_bcd(count_bcd),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    int         m_cnt  = 0;
    int         m_tick = 0;
    int         m_ref  = 0;
    int         m_idx  = 0;
    bit         m_run  = 1'b0;
    logic [7:0] m_led  = 8'h00;
    logic [3:0] m_an   = 4'hF;
    logic       m_ovf  = 1'b0;
    bit         cmp_en = 1'b0;

    logic [7:0] seg_tab [10] = '{8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66,
                                 8'hb6, 8'hbe, 8'he0, 8'hfe, 8'hf6};

    function automatic int pow10(int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(int v);
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int from_bcd_clean(logic [4*N-1:0] b);
        int v = 0;
        int d;
        for (int i = N - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 0;
            v = v * 10 + d;
        end
        return v;
    endfunction

    // A slot shows nothing when the whole value fits in the slots below it.
    function automatic bit lead_blank(int v, int idx);
`ifdef LEADING_ZERO_BLANK_EN
        return (idx != 0) && (v < pow10(idx));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge with the inputs that were present.
    task automatic model_edge(input bit s, input bit p, input bit c, input bit l,
                              input logic [4*N-1:0] lv);
        bit inc;
        m_led = lead_blank(m_cnt, m_idx) ? 8'h00 : seg_tab[(m_cnt / pow10(m_idx)) % 10];
        m_an  = ~(4'b0001 << m_idx);
        inc   = m_run && (m_tick == TD - 1);
        m_ovf = 1'b0;
        if (c) begin
            m_cnt  = 0;
            m_tick = 0;
        end else if (l) begin
            m_cnt  = from_bcd_clean(lv);
            m_tick = 0;
        end else begin
            if (m_run) m_tick = (m_tick + 1) % TD;
            if (inc) begin
                m_ovf = (m_cnt == pow10(N) - 1);
                m_cnt = (m_cnt + 1) % pow10(N);
            end
        end
        if (s && !p) m_run = 1'b1;
        else if (p && !s) m_run = 1'b0;
        if (m_ref == RD - 1) begin
            m_ref = 0;
            m_idx = (m_idx + 1) % N;
        end else begin
            m_ref++;
        end
    endtask

    task automatic cycle(input bit s, input bit p, input bit c, input bit l,
                         input logic [4*N-1:0] lv);
        start = s; stop = p; clr = c; load = l; load_val = lv;
        @(posedge clk);
        model_edge(s, p, c, l, lv);
        #1;
        start = 1'b0; stop = 1'b0; clr = 1'b0; load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        m_cnt  = 0; m_tick = 0; m_ref = 0; m_idx = 0; m_run = 1'b0;
        m_led  = 8'h00; m_an = 4'hF; m_ovf = 1'b0;
        #1;
        chk("rst_led", 32'(LED), 32'h00);
        chk("rst_an", 32'(AN), 32'hF);
        chk("rst_count", 32'(count_bcd), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_led", 32'(LED), 32'(m_led));
            chk("model_an", 32'(AN), 32'(m_an));
            chk("model_count", 32'(count_bcd), 32'(to_bcd(m_cnt)));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    function automatic logic [3:0] next_an(logic [3:0] a);
        case (a)
            4'hE:    return 4'hD;
            4'hD:    return 4'hB;
            4'hB:    return 4'h7;
            default: return 4'hE;
        endcase
    endfunction

    function automatic logic [7:0] led_1234(logic [3:0] a);
        case (a)
            4'hE:    return 8'h66;
            4'hD:    return 8'hf2;
            4'hB:    return 8'hda;
            4'h7:    return 8'h60;
            default: return 8'hxx;
        endcase
    endfunction

    function automatic logic [7:0] led_0007(logic [3:0] a);
        if (a == 4'hE) return 8'he0;
`ifdef LEADING_ZERO_BLANK_EN
        return 8'h00;
`else
        return 8'hfc;
`endif
    endfunction

    initial begin
        logic [3:0] prev_an;
        int         changes;
        int         r;
        logic [15:0] lv;

        do_reset();
        cmp_en = 1'b1;

        // STOP after reset: count holds for 3 tick periods
        idle(3 * TD);
        chk("stop_hold", 32'(count_bcd), 32'h0000);

        // Run timing
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(4);
        chk("run_4", 32'(count_bcd), 32'h0001);
        idle(4);
        chk("run_8", 32'(count_bcd), 32'h0002);
        idle(32);
        chk("run_40", 32'(count_bcd), 32'h0010);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(10);
        chk("stop_val", 32'(count_bcd), 32'h0010);

        // Reset while running with 0x0123 loaded
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        chk("pre_rst", 32'(count_bcd), 32'h0123);
        do_reset();
        idle(3 * TD);
        chk("post_rst", 32'(count_bcd), 32'h0000);

        // Wrap 9999 -> 0000 with a single-cycle ovf
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(3);
        chk("wrap_pre", 32'(count_bcd), 32'h9999);
        idle(1);
        chk("wrap_cnt", 32'(count_bcd), 32'h0000);
        chk("wrap_ovf", 32'(ovf), 32'h1);
        idle(1);
        chk("wrap_ovf_end", 32'(ovf), 32'h0);
        // clr+load on the cycle an increment is due
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h5555);
        chk("prio_clr", 32'(count_bcd), 32'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h12A4);
        chk("load_clean", 32'(count_bcd), 32'h1204);

        // Scan of 0x1234
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
        idle(1);
        prev_an = AN;
        changes = 0;
        for (int k = 0; k < 12; k++) begin
            idle(1);
            chk("scan_led", 32'(LED), 32'(led_1234(AN)));
            if (AN != prev_an) begin
                changes++;
                chk("scan_order", 32'(AN), 32'(next_an(prev_an)));
            end
            prev_an = AN;
        end
        chk("scan_steps", 32'(changes), 32'd4);

        // start+stop together leaves the state alone
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(8);
        chk("ss_stop", 32'(count_bcd), 32'h1234);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(6);
        chk("ss_run", 32'(count_bcd), 32'h1236);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Leading zeros, 0x0007
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0007);
        idle(1);
        for (int k = 0; k < 12; k++) begin
            idle(1);
            chk("lz_led", 32'(LED), 32'(led_0007(AN)));
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            r  = $urandom_range(0, 99);
            lv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lv = {8'h99, lv[7:0]};
            cycle(r < 5, (r >= 5 && r < 8) || r == 95, r == 8 || r == 95,
                  r == 9 || r == 10 || r == 96, lv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
